// File: rtl/dbg_disp_pkg.sv
// Shared 7-segment encodings and constants for the CPU debug display path.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package dbg_disp_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   // Widest anode vector; narrower displays take the low bits.
   localparam logic [7:0] AN_OFF = 8'hFF;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] seg;
      seg = SEG_BLANK;
      unique case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/sseg_digit_dec.sv
// Combinational decode of one hex digit (with blanking and decimal point)
// to the active-low {dp,g,f,e,d,c,b,a} segment bus.
module sseg_digit_dec
   import dbg_disp_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       blank_i,
   input  logic       dp_i,
   output logic [7:0] sseg_o
);

   logic [6:0] seg;

   always_comb begin
      seg = hex_to_seg(nibble_i);
      if (blank_i) begin
         seg = SEG_BLANK;
      end
      // The decimal point stays live even on a blanked digit.
      sseg_o = {dp_i, seg};
   end

endmodule

// File: rtl/dbg_disp_mux.sv
// Debug display multiplexer: picks one of N_SRC debug words (manual or auto-cycled),
// optionally freezes it, and scans it as hex onto a common-anode 7-segment display.
module dbg_disp_mux
   import dbg_disp_pkg::*;
#(
   parameter int unsigned N_SRC      = 4,
   parameter int unsigned N_DIGITS   = 8,
   parameter int unsigned SCAN_CNT_W = 17,
   parameter int unsigned AUTO_CNT_W = 27
) (
   input  logic                          clk_100M,
   input  logic                          rst,
   input  logic [N_SRC*4*N_DIGITS-1:0]   src_data,
   input  logic [$clog2(N_SRC)-1:0]      sel,
   input  logic                          auto_en,
   input  logic                          freeze,
   input  logic                          blank_lz,
   input  logic [N_DIGITS-1:0]           dp_in,
   output logic [N_DIGITS-1:0]           an,
   output logic [7:0]                    sseg,
   output logic [$clog2(N_SRC)-1:0]      cur_src
);

   localparam int unsigned W     = 4 * N_DIGITS;
   localparam int unsigned SEL_W = $clog2(N_SRC);
   localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   logic [SCAN_CNT_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [AUTO_CNT_W-1:0] auto_cnt_q, auto_cnt_d;
   logic [SEL_W-1:0]      cur_src_q, cur_src_d;
   logic [W-1:0]          view_q, view_d;
   logic [N_DIGITS-1:0]   an_q, an_d;
   logic [7:0]            sseg_q, sseg_d;

   logic [W-1:0]          src_word;
   logic [3:0]            dig_nibble;
   logic                  dig_dp;
   logic                  dig_blank;
   logic [N_DIGITS-1:0]   zero_from;
   logic                  zero_acc;

   // Source mux driven by the latched index, not by sel directly.
   always_comb begin
      src_word = '0;
      for (int k = 0; k < int'(N_SRC); k++) begin
         if (cur_src_q == SEL_W'(k)) begin
            src_word = src_data[k*W +: W];
         end
      end
   end

   // zero_from[i]: every nibble from position i up to the top is zero.
   always_comb begin
      zero_from = '0;
      zero_acc  = 1'b1;
      for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
         zero_acc     = zero_acc & (view_q[4*i +: 4] == 4'h0);
         zero_from[i] = zero_acc;
      end
   end

   always_comb begin
      dig_nibble = 4'h0;
      dig_dp     = 1'b1;
      dig_blank  = 1'b0;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         if (idx_q == IDX_W'(i)) begin
            dig_nibble = view_q[4*i +: 4];
            dig_dp     = dp_in[i];
            dig_blank  = blank_lz && (i != 0) && zero_from[i];
         end
      end
   end

   sseg_digit_dec u_digit_dec (
      .nibble_i (dig_nibble),
      .blank_i  (dig_blank),
      .dp_i     (dig_dp),
      .sseg_o   (sseg_d)
   );

   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;

      idx_d = idx_q;
      if (&scan_cnt_q) begin
         idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end

      // Holding the counter at zero while manual makes each auto run start fresh.
      auto_cnt_d = auto_en ? auto_cnt_q + 1'b1 : '0;

      cur_src_d = cur_src_q;
      if (auto_en) begin
         if (&auto_cnt_q) begin
            cur_src_d = (cur_src_q == SEL_W'(N_SRC - 1)) ? '0 : cur_src_q + 1'b1;
         end
      end else if (32'(sel) >= N_SRC) begin
         cur_src_d = '0;
      end else begin
         cur_src_d = sel;
      end

      view_d = freeze ? view_q : src_word;

      an_d = ~(N_DIGITS'(1) << idx_q);
   end

   always_ff @(posedge clk_100M) begin
      if (rst) begin
         scan_cnt_q <= '0;
         idx_q      <= '0;
         auto_cnt_q <= '0;
         cur_src_q  <= '0;
         view_q     <= '0;
         an_q       <= AN_OFF[N_DIGITS-1:0];
         sseg_q     <= 8'hFF;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         auto_cnt_q <= auto_cnt_d;
         cur_src_q  <= cur_src_d;
         view_q     <= view_d;
         an_q       <= an_d;
         sseg_q     <= sseg_d;
      end
   end

   assign an      = an_q;
   assign sseg    = sseg_q;
   assign cur_src = cur_src_q;

endmodule

// File: tb/tb_dbg_disp_mux.sv
// Directed bench for dbg_disp_mux with short scan/auto counters so a full
// digit sweep and source rotation fit in a few dozen cycles.
module tb_dbg_disp_mux;

   localparam int unsigned NS = 4;
   localparam int unsigned ND = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [NS*32-1:0] src_data;
   logic [1:0]    sel;
   logic          auto_en;
   logic          freeze;
   logic          blank_lz;
   logic [7:0]    dp_in;
   logic [7:0]    an;
   logic [7:0]    sseg;
   logic [1:0]    cur_src;
   logic [7:0]    an3;
   logic [7:0]    sseg3;
   logic [1:0]    cur_src3;

   int tests_run;
   int tests_failed;

   always #5 clk = ~clk;

   dbg_disp_mux #(
      .N_SRC      (NS),
      .N_DIGITS   (ND),
      .SCAN_CNT_W (2),
      .AUTO_CNT_W (3)
   ) dut (
      .clk_100M (clk),
      .rst      (rst),
      .src_data (src_data),
      .sel      (sel),
      .auto_en  (auto_en),
      .freeze   (freeze),
      .blank_lz (blank_lz),
      .dp_in    (dp_in),
      .an       (an),
      .sseg     (sseg),
      .cur_src  (cur_src)
   );

   dbg_disp_mux #(
      .N_SRC      (3),
      .N_DIGITS   (ND),
      .SCAN_CNT_W (2),
      .AUTO_CNT_W (3)
   ) dut3 (
      .clk_100M (clk),
      .rst      (rst),
      .src_data (src_data[3*32-1:0]),
      .sel      (sel),
      .auto_en  (auto_en),
      .freeze   (freeze),
      .blank_lz (blank_lz),
      .dp_in    (dp_in),
      .an       (an3),
      .sseg     (sseg3),
      .cur_src  (cur_src3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      repeat (n) tick();
   endtask

   task automatic set_src(input int k, input logic [31:0] val);
      src_data[k*32 +: 32] = val;
   endtask

   // Advance until digit k is lit; ok=0 if it never appears within the budget.
   task automatic wait_digit(input int k, output bit ok);
      logic [7:0] target;
      target = ~(8'(1) << k);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (an === target) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tests_run++;
      if (an !== 8'hFF) begin
         tests_failed++;
         $display("FAIL reset_an: got %h expected ff", an);
      end
      tests_run++;
      if (sseg !== 8'hFF) begin
         tests_failed++;
         $display("FAIL reset_sseg: got %h expected ff", sseg);
      end
      tests_run++;
      if (cur_src !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_cur_src: got %0d expected 0", cur_src);
      end
      rst = 1'b0;
   endtask

   task automatic test_scan();
      tick();
      tests_run++;
      if (an !== 8'hFE) begin
         tests_failed++;
         $display("FAIL scan_first: got %h expected fe", an);
      end
      tick_n(3);
      tests_run++;
      if (an !== 8'hFE) begin
         tests_failed++;
         $display("FAIL scan_hold: got %h expected fe", an);
      end
      tick();
      tests_run++;
      if (an !== 8'hFD) begin
         tests_failed++;
         $display("FAIL scan_step: got %h expected fd", an);
      end
      tick_n(27);
      tests_run++;
      if (an !== 8'h7F) begin
         tests_failed++;
         $display("FAIL scan_last: got %h expected 7f", an);
      end
      tick();
      tests_run++;
      if (an !== 8'hFE) begin
         tests_failed++;
         $display("FAIL scan_wrap: got %h expected fe", an);
      end
   endtask

   task automatic test_blank();
      bit ok;
      logic [7:0] exp_seg [8];
      exp_seg = '{8'h92, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      set_src(0, 32'h0000_00A5);
      sel      = 2'd0;
      blank_lz = 1'b1;
      tick_n(3);
      for (int d = 7; d >= 0; d--) begin
         wait_digit(d, ok);
         tests_run++;
         if (!ok || sseg !== exp_seg[d]) begin
            tests_failed++;
            $display("FAIL blank_digit%0d: got %h (seen=%0d) expected %h", d, sseg, ok,
                     exp_seg[d]);
         end
      end
      blank_lz = 1'b0;
      tick_n(3);
      wait_digit(7, ok);
      tests_run++;
      if (!ok || sseg !== 8'hC0) begin
         tests_failed++;
         $display("FAIL noblank_digit7: got %h (seen=%0d) expected c0", sseg, ok);
      end
   endtask

   task automatic test_src_select();
      set_src(1, 32'h1111_1111);
      set_src(2, 32'h2222_2222);
      set_src(3, 32'h3333_3333);
      sel = 2'd1;
      tick();
      tests_run++;
      if (cur_src !== 2'd1) begin
         tests_failed++;
         $display("FAIL sel_1: got %0d expected 1", cur_src);
      end
      sel = 2'd3;
      tick();
      tests_run++;
      if (cur_src !== 2'd3) begin
         tests_failed++;
         $display("FAIL sel_3: got %0d expected 3", cur_src);
      end
      tests_run++;
      if (cur_src3 !== 2'd0) begin
         tests_failed++;
         $display("FAIL sel_clamp: got %0d expected 0", cur_src3);
      end
      tick();
      tests_run++;
      if (dut.view_q !== 32'h3333_3333) begin
         tests_failed++;
         $display("FAIL view_src3: got %h expected 33333333", dut.view_q);
      end
   endtask

   task automatic test_auto();
      logic [1:0] exp_src [4];
      exp_src = '{2'd1, 2'd2, 2'd3, 2'd0};
      sel = 2'd0;
      tick();
      auto_en = 1'b1;
      tick_n(7);
      tests_run++;
      if (cur_src !== 2'd0) begin
         tests_failed++;
         $display("FAIL auto_hold: got %0d expected 0", cur_src);
      end
      tick();
      for (int s = 0; s < 4; s++) begin
         if (s != 0) tick_n(8);
         tests_run++;
         if (cur_src !== exp_src[s]) begin
            tests_failed++;
            $display("FAIL auto_step%0d: got %0d expected %0d", s, cur_src, exp_src[s]);
         end
      end
      auto_en = 1'b0;
      sel     = 2'd2;
      tick();
      tests_run++;
      if (cur_src !== 2'd2) begin
         tests_failed++;
         $display("FAIL auto_exit: got %0d expected 2", cur_src);
      end
   endtask

   task automatic test_freeze();
      bit ok;
      sel = 2'd0;
      set_src(0, 32'h1234_5678);
      tick_n(3);
      freeze = 1'b1;
      tick();
      set_src(0, 32'hFFFF_FFFF);
      tick_n(3);
      tests_run++;
      if (dut.view_q !== 32'h1234_5678) begin
         tests_failed++;
         $display("FAIL freeze_view: got %h expected 12345678", dut.view_q);
      end
      wait_digit(7, ok);
      tests_run++;
      if (!ok || sseg !== 8'hF9) begin
         tests_failed++;
         $display("FAIL freeze_digit7: got %h (seen=%0d) expected f9", sseg, ok);
      end
      wait_digit(0, ok);
      tests_run++;
      if (!ok || sseg !== 8'h80) begin
         tests_failed++;
         $display("FAIL freeze_digit0: got %h (seen=%0d) expected 80", sseg, ok);
      end
      freeze = 1'b0;
      tick();
      tests_run++;
      if (dut.view_q !== 32'hFFFF_FFFF) begin
         tests_failed++;
         $display("FAIL unfreeze_view: got %h expected ffffffff", dut.view_q);
      end
      tick_n(3);
      wait_digit(3, ok);
      tests_run++;
      if (!ok || sseg !== 8'h8E) begin
         tests_failed++;
         $display("FAIL unfreeze_digit3: got %h (seen=%0d) expected 8e", sseg, ok);
      end
   endtask

   task automatic test_reset_mid();
      sel     = 2'd1;
      auto_en = 1'b1;
      freeze  = 1'b1;
      dp_in   = 8'h00;
      tick_n(5);
      rst = 1'b1;
      tick();
      tests_run++;
      if (an !== 8'hFF || sseg !== 8'hFF) begin
         tests_failed++;
         $display("FAIL midreset_disp: got an=%h sseg=%h expected an=ff sseg=ff", an, sseg);
      end
      tests_run++;
      if (cur_src !== 2'd0) begin
         tests_failed++;
         $display("FAIL midreset_cur_src: got %0d expected 0", cur_src);
      end
      tests_run++;
      if (dut.view_q !== 32'h0) begin
         tests_failed++;
         $display("FAIL midreset_view: got %h expected 00000000", dut.view_q);
      end
      rst     = 1'b0;
      auto_en = 1'b0;
      freeze  = 1'b0;
      sel     = 2'd0;
      set_src(0, 32'h0);
      tick();
      tests_run++;
      if (an !== 8'hFE || sseg !== 8'h40) begin
         tests_failed++;
         $display("FAIL postreset_dp: got an=%h sseg=%h expected an=fe sseg=40", an, sseg);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst      = 1'b1;
      src_data = '0;
      sel      = 2'd0;
      auto_en  = 1'b0;
      freeze   = 1'b0;
      blank_lz = 1'b0;
      dp_in    = 8'hFF;

      test_reset();
      test_scan();
      test_blank();
      test_src_select();
      test_auto();
      test_freeze();
      test_reset_mid();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dbg_disp_mux.md
Name: dbg_disp_mux

Overview:
- Parametrised successor to the fixed 8-digit, 3-way CPU debug display path.
- Selects one of N_SRC 32-bit-class debug words (instr, RF debug, mem debug, PC, ...) and scans it onto an N_DIGITS common-anode 7-segment display.
- Adds auto-cycle through sources, freeze/snapshot, leading-zero blanking and clamped selection, which the current path lacks.
- Sits in cpu_top between the CPU/RAM debug ports and the board an/sseg pins.

Parameters:
- N_SRC, 4, number of debug sources (2..16).
- N_DIGITS, 8, number of hex digits/anodes (1..8); word width W = 4*N_DIGITS.
- SCAN_CNT_W, 17, scan counter width; digit advances every 2^SCAN_CNT_W cycles.
- AUTO_CNT_W, 27, auto-cycle counter width; source advances every 2^AUTO_CNT_W cycles.

Ports:
- clk_100M, input, 1: system clock; all state changes on its rising edge.
- rst, input, 1: synchronous active-high reset.
- src_data, input, N_SRC*W: concatenated sources; source k = src_data[k*W +: W].
- sel, input, $clog2(N_SRC): manual source select.
- auto_en, input, 1: 1 = auto-cycle sources, 0 = manual via sel.
- freeze, input, 1: 1 = hold the currently displayed word.
- blank_lz, input, 1: 1 = blank leading zero digits.
- dp_in, input, N_DIGITS: decimal points, active-low, per digit.
- an, output, N_DIGITS: anodes, active-low, one-hot-low.
- sseg, output, 8: {dp, g,f,e,d,c,b,a}, active-low.
- cur_src, output, $clog2(N_SRC): source index currently latched into the view.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - an = all 1s; sseg = 8'hFF.
  - cur_src = 0; view register = 0.
  - Scan counter, digit index and auto counter = 0.
  - rst overrides every other input on the same edge.
  - Reset asserted mid-scan or mid-freeze returns to this state in one cycle.
- Scan:
  - Scan counter increments every cycle.
  - When the counter is all 1s, the digit index advances the next cycle and wraps N_DIGITS-1 -> 0.
  - an/sseg are registered from the digit index: one cycle of latency after the index changes.
  - Exactly one an bit is 0 after reset exits. In the first cycle after reset, an = all 1s.
- Source select:
  - auto_en=0: cur_src <= sel each cycle. If sel >= N_SRC, cur_src <= 0.
  - auto_en=1: the auto counter increments. On all 1s, cur_src increments and wraps N_SRC-1 -> 0.
  - auto_en 0->1 starts the auto counter from 0.
  - auto_en 1->0 loads sel on the next edge.
- View register:
  - freeze=0: view <= source[cur_src] every cycle. Display lags cur_src by one cycle.
  - freeze=1: view holds; cur_src may keep changing.
  - On freeze release, view reloads on the next edge.
- Digit decode:
  - Nibble = view[4*idx +: 4].
  - Hex map, gfedcba active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
  - sseg[7] = dp_in[idx].
- Leading-zero blanking:
  - Applies when blank_lz=1 and idx != 0.
  - Digit idx is blanked when all nibbles at positions idx..N_DIGITS-1 are zero.
  - Blanked digit: segments = 7'h7F, dp still driven from dp_in.
  - Digit 0 is never blanked. Value 0 therefore shows a single "0".
- Width rules:
  - W < 32 truncates the upper source bits at the integration level, not in this block.
  - Counters wrap modulo 2^width with no saturation.

Decomposition:
- Package dbg_disp_pkg contains:
  - function hex_to_seg(logic [3:0]) -> logic [6:0];
  - constant SEG_BLANK = 7'h7F;
  - constant AN_OFF helper (all 1s).
- Sub-module sseg_digit_dec:
  - Combinational nibble/blank/dp to 8-bit sseg.
  - Instantiated once on the muxed digit.
- Counters, source select and view register are in the top of dbg_disp_mux.

Test Plan:
1. SCAN_CNT_W=2, N_DIGITS=8, reset release -> an = 8'hFF for 1 cycle, then 8'hFE; an steps to 8'hFD after 4 cycles; back to 8'hFE after 32 cycles.
2. src0=32'h0000_00A5, blank_lz=1 -> digits 7..2 sseg=8'hFF; digit1 sseg=8'h88 (A); digit0 sseg=8'h92 (5). Set blank_lz=0 -> digit7 shows 8'hC0.
3. N_SRC=4, sel=1 then sel=3 -> cur_src 1 then 3 one cycle later; view equals src3 one further cycle later. With N_SRC=3 and sel=3 -> cur_src=0.
4. AUTO_CNT_W=3, auto_en=1 -> cur_src 0->1->2->3->0, one step per 8 cycles. Drop auto_en with sel=2 -> cur_src=2 next edge.
5. freeze=1 while src0=32'h1234_5678, then change src0 to 32'hFFFF_FFFF -> display stays 12345678. Release freeze -> FFFFFFFF after 1 cycle.
6. Assert rst mid-scan with freeze=1 and auto_en=1 -> next edge an=8'hFF, sseg=8'hFF, cur_src=0, view=0; dp_in=8'h00 affects sseg[7] only after reset.
